// File: rtl/instruction_encoder_pkg.sv
// Opcode, format and field definitions shared by the instruction encoder and decoder.
// Pure definitions: no state, no latency, no flow control.
package instruction_encoder_pkg;

   localparam int INSTR_W = 8;

   localparam logic [3:0] OP_0 = 4'h0, OP_1 = 4'h1, OP_2 = 4'h2, OP_3 = 4'h3;
   localparam logic [3:0] OP_4 = 4'h4, OP_5 = 4'h5, OP_6 = 4'h6, OP_7 = 4'h7;
   localparam logic [3:0] OP_8 = 4'h8, OP_9 = 4'h9, OP_A = 4'hA, OP_B = 4'hB;
   localparam logic [3:0] OP_C = 4'hC, OP_D = 4'hD, OP_E = 4'hE, OP_F = 4'hF;

   typedef enum logic [1:0] {
      FMT_IMM4 = 2'd0,
      FMT_RI   = 2'd1,
      FMT_RR   = 2'd2
   } fmt_e;

   typedef struct packed {
      logic [3:0] opcode;
      logic [1:0] rd;
      logic [1:0] rs;
      logic [1:0] imm2;
      logic [3:0] imm4;
   } fields_t;

   function automatic fmt_e op_format(input logic [3:0] op);
      case (op)
         OP_0, OP_1:                               op_format = FMT_IMM4;
         OP_3, OP_4, OP_5, OP_6, OP_7, OP_8, OP_A: op_format = FMT_RR;
         OP_2, OP_9, OP_B, OP_C, OP_D, OP_E, OP_F: op_format = FMT_RI;
         default:                                  op_format = FMT_RI;
      endcase
   endfunction

   function automatic logic [INSTR_W-1:0] encode(input fields_t f);
      logic [3:0] lo;
      case (op_format(f.opcode))
         FMT_IMM4: lo = f.imm4;
         FMT_RI:   lo = {f.rd, f.imm2};
         default:  lo = {f.rd, f.rs};
      endcase
      return {f.opcode, lo};
   endfunction

   // A field is illegal when a slot the format does not use carries a nonzero value.
   function automatic logic field_illegal(input fields_t f);
      case (op_format(f.opcode))
         FMT_IMM4: return |{f.rd, f.rs, f.imm2};
         FMT_RI:   return |{f.rs, f.imm4};
         default:  return |{f.imm2, f.imm4};
      endcase
   endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Field-input and program-memory write bundle of the instruction encoder.
// slave = encoder side, master = loader/memory side.
interface instruction_encoder_if #(parameter int ADDR_W = 4);
   import instruction_encoder_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [3:0]          opcode;
   logic [1:0]          rd;
   logic [1:0]          rs;
   logic [1:0]          imm2;
   logic [3:0]          imm4;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [INSTR_W-1:0]  mem_wdata;
   logic                mem_ready;
   logic [ADDR_W:0]     count;
   logic                prog_full;
   logic                err;

   modport slave (
      input  in_valid, opcode, rd, rs, imm2, imm4, mem_ready,
      output in_ready, mem_we, mem_addr, mem_wdata, count, prog_full, err
   );

   modport master (
      output in_valid, opcode, rd, rs, imm2, imm4, mem_ready,
      input  in_ready, mem_we, mem_addr, mem_wdata, count, prog_full, err
   );
endinterface

// File: rtl/instruction_encoder_fifo.sv
// Synchronous word FIFO with flush; push visible at the head one cycle later.
// Push ignored when full, pop ignored when empty; storage cleared on reset/flush.
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] pop_dat,
   output logic         full,
   output logic         empty
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [PW:0]  r_wr;
   logic [PW:0]  r_rd;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty   = (r_wr == r_rd);
   assign full    = (r_wr[PW] != r_rd[PW]) && (r_wr[PW-1:0] == r_rd[PW-1:0]);
   assign pop_dat = r_mem[r_rd[PW-1:0]];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wr <= '0;
         r_rd <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (push && !full) begin
            r_mem[r_wr[PW-1:0]] <= push_dat;
            r_wr                <= r_wr + (PW+1)'(1);
         end
         if (pop && !empty) r_rd <= r_rd + (PW+1)'(1);
      end
   end
endmodule

// File: rtl/instruction_encoder.sv
// Packs instruction fields into 8-bit words and streams them into program memory in order (min 1 cycle accept->write).
// in_ready drops on FIFO full or capacity reached; writes stall on mem_ready. ENC_FIELD_CHECK_EN enables illegal-field detection.
module instruction_encoder
   import instruction_encoder_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   instruction_encoder_if.slave  bus
);
   localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

   fields_t             w_f;
   logic [INSTR_W-1:0]  w_word;
   logic [INSTR_W-1:0]  w_head;
   logic                w_full;
   logic                w_empty;
   logic                w_accept;
   logic                w_push;
   logic                w_pop;
   logic                w_illegal;

   logic [ADDR_W:0]     r_acc_cnt;
   logic [ADDR_W:0]     r_count;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_prog_full;

   assign w_f    = {bus.opcode, bus.rd, bus.rs, bus.imm2, bus.imm4};
   assign w_word = encode(w_f);

   // Ready never looks at the pop path, so a full FIFO stays not-ready even while draining.
   assign bus.in_ready = !rst && !clr && !w_full && !r_prog_full && (r_acc_cnt < CAP);
   assign w_accept     = bus.in_valid && bus.in_ready;
   assign w_push       = w_accept && !w_illegal;

   assign bus.mem_we    = !w_empty && !r_prog_full;
   assign bus.mem_wdata = w_head;
   assign bus.mem_addr  = r_addr;
   assign bus.count     = r_count;
   assign bus.prog_full = r_prog_full;
   assign w_pop         = bus.mem_we && bus.mem_ready && !rst && !clr;

`ifdef ENC_FIELD_CHECK_EN
   logic r_err;

   assign w_illegal = field_illegal(w_f);
   assign bus.err   = r_err;

   always_ff @(posedge clk) begin
      if (rst || clr)                 r_err <= 1'b0;
      else if (w_accept && w_illegal) r_err <= 1'b1;
   end
`else
   assign w_illegal = 1'b0;
   assign bus.err   = 1'b0;
`endif

   instr_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (clr),
      .push     (w_push),
      .push_dat (w_word),
      .pop      (w_pop),
      .pop_dat  (w_head),
      .full     (w_full),
      .empty    (w_empty)
   );

   // The last address completing fills the program; the address wraps but writes stop.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_acc_cnt   <= '0;
         r_count     <= '0;
         r_addr      <= '0;
         r_prog_full <= 1'b0;
      end else begin
         if (w_push) r_acc_cnt <= r_acc_cnt + (ADDR_W+1)'(1);
         if (w_pop) begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_count <= r_count + (ADDR_W+1)'(1);
            if (&r_addr) r_prog_full <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_instruction_encoder.sv
// Directed and randomized bench for instruction_encoder against a queue-based reference model.
// Two instances: ADDR_W=4 for function/backpressure/clear, ADDR_W=2 for the capacity boundary.
module tb_instruction_encoder;
   localparam int DEPTH = 4;
`ifdef ENC_FIELD_CHECK_EN
   localparam bit FCHK = 1'b1;
`else
   localparam bit FCHK = 1'b0;
`endif

   logic clk  = 1'b0;
   logic rst0 = 1'b1, clr0 = 1'b0;
   logic rst1 = 1'b1, clr1 = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   instruction_encoder_if #(.ADDR_W(4)) b0 ();
   instruction_encoder_if #(.ADDR_W(2)) b1 ();

   instruction_encoder #(.DEPTH(DEPTH), .ADDR_W(4)) u0 (.clk(clk), .rst(rst0), .clr(clr0), .bus(b0.slave));
   instruction_encoder #(.DEPTH(DEPTH), .ADDR_W(2)) u1 (.clk(clk), .rst(rst1), .clr(clr1), .bus(b1.slave));

   // Opcode format tables: bit n set means opcode n belongs to that format.
   logic [15:0] imm4_ops = 16'h0003;
   logic [15:0] rr_ops   = 16'h05F8;

   // Reference model state, one slot per instance.
   int         m_q0[$];
   int         m_q1[$];
   int         m_acc[2]  = '{0, 0};
   int         m_addr[2] = '{0, 0};
   int         m_cnt[2]  = '{0, 0};
   bit         m_pf[2]   = '{1'b0, 1'b0};
   bit         m_err[2]  = '{1'b0, 1'b0};
   logic [7:0] log0[16];
   logic [7:0] log1[4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic int ref_word(input int op, input int rd, input int rs, input int i2, input int i4);
      if (imm4_ops[op]) return op * 16 + i4;
      if (rr_ops[op])   return op * 16 + rd * 4 + rs;
      return op * 16 + rd * 4 + i2;
   endfunction

   function automatic bit ref_illegal(input int op, input int rd, input int rs, input int i2, input int i4);
      if (imm4_ops[op]) return (rd != 0) || (rs != 0) || (i2 != 0);
      if (rr_ops[op])   return (i2 != 0) || (i4 != 0);
      return (rs != 0) || (i4 != 0);
   endfunction

   // Called once per cycle, after inputs settle and before the next rising edge.
   task automatic model_step(input int id, input int cap, input logic rstv, input logic clrv,
                             input logic iv, input logic ir, input logic [3:0] op, input logic [1:0] rd,
                             input logic [1:0] rs, input logic [1:0] i2, input logic [3:0] i4,
                             input logic we, input logic mr, input logic [31:0] addr, input logic [7:0] wd,
                             input logic [31:0] cnt, input logic pf, input logic er);
      int    qsz;
      int    head;
      bit    exp_rdy;
      bit    exp_we;
      string p;
      p    = (id == 0) ? "u0" : "u1";
      qsz  = (id == 0) ? m_q0.size() : m_q1.size();
      head = 0;
      if (qsz > 0) head = (id == 0) ? m_q0[0] : m_q1[0];
      exp_rdy = !rstv && !clrv && (qsz < DEPTH) && !m_pf[id] && (m_acc[id] < cap);
      exp_we  = (qsz > 0) && !m_pf[id];

      check({p, ".in_ready"},  {31'd0, ir}, {31'd0, exp_rdy});
      check({p, ".mem_we"},    {31'd0, we}, {31'd0, exp_we});
      check({p, ".count"},     cnt, m_cnt[id]);
      check({p, ".prog_full"}, {31'd0, pf}, {31'd0, m_pf[id]});
      check({p, ".err"},       {31'd0, er}, {31'd0, m_err[id]});
      check({p, ".mem_addr"},  addr, m_addr[id]);
      if (exp_we) check({p, ".mem_wdata"}, {24'd0, wd}, head);

      if (rstv || clrv) begin
         if (id == 0) m_q0.delete(); else m_q1.delete();
         m_acc[id] = 0; m_addr[id] = 0; m_cnt[id] = 0; m_pf[id] = 1'b0; m_err[id] = 1'b0;
      end else begin
         if (exp_we && mr) begin
            if (id == 0) begin log0[addr] = wd; void'(m_q0.pop_front()); end
            else         begin log1[addr] = wd; void'(m_q1.pop_front()); end
            m_addr[id] = (m_addr[id] + 1) % cap;
            m_cnt[id]++;
            if (m_cnt[id] == cap) m_pf[id] = 1'b1;
         end
         if (iv && exp_rdy) begin
            if (FCHK && ref_illegal(op, rd, rs, i2, i4)) m_err[id] = 1'b1;
            else begin
               if (id == 0) m_q0.push_back(ref_word(op, rd, rs, i2, i4));
               else         m_q1.push_back(ref_word(op, rd, rs, i2, i4));
               m_acc[id]++;
            end
         end
      end
   endtask

   always @(negedge clk) begin
      #2;
      model_step(0, 16, rst0, clr0, b0.in_valid, b0.in_ready, b0.opcode, b0.rd, b0.rs, b0.imm2, b0.imm4,
                 b0.mem_we, b0.mem_ready, 32'(b0.mem_addr), b0.mem_wdata, 32'(b0.count), b0.prog_full, b0.err);
      model_step(1, 4, rst1, clr1, b1.in_valid, b1.in_ready, b1.opcode, b1.rd, b1.rs, b1.imm2, b1.imm4,
                 b1.mem_we, b1.mem_ready, 32'(b1.mem_addr), b1.mem_wdata, 32'(b1.count), b1.prog_full, b1.err);
   end

   task automatic set0(input logic v, input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [1:0] i2, input logic [3:0] i4);
      b0.in_valid = v; b0.opcode = op; b0.rd = rd; b0.rs = rs; b0.imm2 = i2; b0.imm4 = i4;
   endtask

   // Offers one field set to u0 until it is accepted (bounded), then drops valid.
   task automatic send0(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                        input logic [1:0] i2, input logic [3:0] i4);
      bit ok;
      ok = 1'b0;
      set0(1'b1, op, rd, rs, i2, i4);
      for (int n = 0; n < 40 && !ok; n++) begin
         #1;
         ok = b0.in_ready;
         @(negedge clk);
      end
      b0.in_valid = 1'b0;
      check("u0.send_accepted", {31'd0, ok}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] op, i4;
      logic [1:0] rd, rs, i2;
      int k;
      set0(1'b0, 4'h0, 2'd0, 2'd0, 2'd0, 4'h0);
      b0.mem_ready = 1'b0;
      b1.in_valid = 1'b0; b1.opcode = 4'h0; b1.rd = 2'd0; b1.rs = 2'd0; b1.imm2 = 2'd0; b1.imm4 = 4'h0;
      b1.mem_ready = 1'b0;
      repeat (2) @(negedge clk);

      check("rst.in_ready",  {31'd0, b0.in_ready}, 32'd0);
      check("rst.mem_we",    {31'd0, b0.mem_we}, 32'd0);
      check("rst.mem_addr",  32'(b0.mem_addr), 32'd0);
      check("rst.mem_wdata", 32'(b0.mem_wdata), 32'd0);
      check("rst.count",     32'(b0.count), 32'd0);
      check("rst.prog_full", {31'd0, b0.prog_full}, 32'd0);
      check("rst.err",       {31'd0, b0.err}, 32'd0);
      rst0 = 1'b0; rst1 = 1'b0;

      // Basic encoding of the three formats
      b0.mem_ready = 1'b1;
      send0(4'h3, 2'd2, 2'd1, 2'd0, 4'h0);
      send0(4'h0, 2'd0, 2'd0, 2'd0, 4'hA);
      send0(4'h9, 2'd3, 2'd0, 2'd2, 4'h0);
      repeat (4) @(negedge clk);
      check("enc.count", 32'(b0.count), 32'd3);
      check("enc.word0", 32'(log0[0]), 32'h39);
      check("enc.word1", 32'(log0[1]), 32'h0A);
      check("enc.word2", 32'(log0[2]), 32'h9E);
      clr0 = 1'b1; @(negedge clk); clr0 = 1'b0;

      // Backpressure: four accepts fill the FIFO, head holds while the memory stalls
      b0.mem_ready = 1'b0;
      k = 0;
      for (int c = 0; c < 8; c++) begin
         set0(1'b1, 4'(3 + k), 2'(k), 2'(3 - k), 2'd0, 4'h0);
         #1;
         if (c > 0) check("bp.stall_wdata", 32'(b0.mem_wdata), 32'h33);
         if (b0.in_ready) k++;
         @(negedge clk);
      end
      check("bp.accepts_at_full", k, 4);
      check("bp.in_ready_full", {31'd0, b0.in_ready}, 32'd0);
      check("bp.addr_held", 32'(b0.mem_addr), 32'd0);
      b0.mem_ready = 1'b1;
      for (int c = 0; c < 20 && k < 6; c++) begin
         set0(1'b1, 4'(3 + k), 2'(k), 2'(3 - k), 2'd0, 4'h0);
         #1;
         if (b0.in_ready) k++;
         @(negedge clk);
      end
      b0.in_valid = 1'b0;
      repeat (8) @(negedge clk);
      check("bp.accepts_total", k, 6);
      check("bp.count", 32'(b0.count), 32'd6);
      for (int i = 0; i < 6; i++) check("bp.word", 32'(log0[i]), ref_word(3 + i, i & 3, (3 - i) & 3, 0, 0));

      // Clear with two words queued and a write offered in the same cycle
      b0.mem_ready = 1'b0;
      send0(4'h1, 2'd0, 2'd0, 2'd0, 4'h7);
      send0(4'h2, 2'd1, 2'd0, 2'd2, 4'h0);
      check("clr.pre_we", {31'd0, b0.mem_we}, 32'd1);
      b0.mem_ready = 1'b1; clr0 = 1'b1;
      #1 check("clr.in_ready", {31'd0, b0.in_ready}, 32'd0);
      @(negedge clk); clr0 = 1'b0; b0.mem_ready = 1'b0;
      check("clr.mem_we", {31'd0, b0.mem_we}, 32'd0);
      check("clr.count", 32'(b0.count), 32'd0);
      check("clr.mem_addr", 32'(b0.mem_addr), 32'd0);
      b0.mem_ready = 1'b1;
      send0(4'h1, 2'd0, 2'd0, 2'd0, 4'h5);
      repeat (3) @(negedge clk);
      check("clr.first_word", 32'(log0[0]), 32'h15);
      check("clr.count_after", 32'(b0.count), 32'd1);

      // Nonzero field the RR format does not use
      send0(4'h3, 2'd2, 2'd1, 2'd0, 4'h5);
      repeat (3) @(negedge clk);
`ifdef ENC_FIELD_CHECK_EN
      check("fchk.err", {31'd0, b0.err}, 32'd1);
      check("fchk.count", 32'(b0.count), 32'd1);
`else
      check("fchk.err", {31'd0, b0.err}, 32'd0);
      check("fchk.count", 32'(b0.count), 32'd2);
      check("fchk.word", 32'(log0[1]), 32'h39);
`endif

      // Reset while a write handshake is being offered
      b0.mem_ready = 1'b0;
      send0(4'h5, 2'd1, 2'd2, 2'd0, 4'h0);
      check("rstmid.pre_we", {31'd0, b0.mem_we}, 32'd1);
      rst0 = 1'b1; b0.mem_ready = 1'b1; b0.in_valid = 1'b1;
      #1 check("rstmid.in_ready", {31'd0, b0.in_ready}, 32'd0);
      @(negedge clk); rst0 = 1'b0; b0.in_valid = 1'b0; b0.mem_ready = 1'b0;
      check("rstmid.count", 32'(b0.count), 32'd0);
      check("rstmid.mem_we", {31'd0, b0.mem_we}, 32'd0);
      check("rstmid.mem_addr", 32'(b0.mem_addr), 32'd0);
      check("rstmid.mem_wdata", 32'(b0.mem_wdata), 32'd0);
      check("rstmid.prog_full", {31'd0, b0.prog_full}, 32'd0);
      check("rstmid.err", {31'd0, b0.err}, 32'd0);

      // Randomized traffic, mostly well-formed fields, one clear midway
      for (int c = 0; c < 160; c++) begin
         op = 4'($urandom); rd = 2'($urandom); rs = 2'($urandom); i2 = 2'($urandom); i4 = 4'($urandom);
         if ($urandom_range(0, 3) != 0) begin
            if (imm4_ops[op])    begin rd = 2'd0; rs = 2'd0; i2 = 2'd0; end
            else if (rr_ops[op]) begin i2 = 2'd0; i4 = 4'h0; end
            else                 begin rs = 2'd0; i4 = 4'h0; end
         end
         set0(1'($urandom_range(0, 1)), op, rd, rs, i2, i4);
         b0.mem_ready = ($urandom_range(0, 3) != 0);
         clr0 = (c == 70);
         @(negedge clk);
      end
      clr0 = 1'b0; b0.in_valid = 1'b0; b0.mem_ready = 1'b1;
      repeat (10) @(negedge clk);
      check("rand.count", 32'(b0.count), m_cnt[0]);

      // Capacity boundary on the 4-word instance
      b1.mem_ready = 1'b1;
      k = 0;
      for (int c = 0; c < 15; c++) begin
         b1.in_valid = 1'b1; b1.opcode = 4'(3 + k); b1.rd = 2'(k); b1.rs = 2'(k + 1);
         b1.imm2 = 2'd0; b1.imm4 = 4'h0;
         #1;
         if (b1.in_ready) k++;
         @(negedge clk);
      end
      check("cap.accepts", k, 4);
      check("cap.prog_full", {31'd0, b1.prog_full}, 32'd1);
      check("cap.mem_we", {31'd0, b1.mem_we}, 32'd0);
      check("cap.in_ready", {31'd0, b1.in_ready}, 32'd0);
      check("cap.count", 32'(b1.count), 32'd4);
      check("cap.addr_wrap", 32'(b1.mem_addr), 32'd0);
      for (int i = 0; i < 4; i++) check("cap.word", 32'(log1[i]), ref_word(3 + i, i & 3, (i + 1) & 3, 0, 0));
      b1.in_valid = 1'b0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Inverse of the processor's instruction decoder: packs opcode, Rd, Rs, imm2 and imm4 fields into 8-bit instruction words.
- Buffers encoded words in a small FIFO and streams them into program memory through a write port with a ready handshake.
- Sits between the test/boot loader, which issues fields, and the instruction memory the processor fetches from.

Parameters:
- DEPTH, 4, FIFO depth in words; power of two, minimum 2.
- ADDR_W, 4, program memory address width; program capacity is 2^ADDR_W words.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- clr  in  1  synchronous program restart (flush and rewind).
- in_valid  in  1  field set on the inputs is valid.
- in_ready  out  1  encoder can accept a field set this cycle.
- opcode  in  4  instruction opcode.
- rd  in  2  destination register field.
- rs  in  2  source register field.
- imm2  in  2  2-bit immediate.
- imm4  in  4  4-bit immediate.
- mem_we  out  1  write request to program memory.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  8  encoded instruction word.
- mem_ready  in  1  memory accepts the write this cycle.
- count  out  ADDR_W+1  number of words written since reset/clr.
- prog_full  out  1  program memory fully written.
- err  out  1  sticky illegal-field flag (see Optional Feature).

Behaviour:
- Encoding: word[7:4] = opcode. The lower nibble depends on the opcode format:
  - IMM4 format (opcodes 0x0, 0x1): word[3:0] = imm4.
  - RI format (opcodes 0x2, 0x9, 0xB-0xF): word[3:2] = rd, word[1:0] = imm2.
  - RR format (opcodes 0x3-0x8, 0xA): word[3:2] = rd, word[1:0] = rs.
  - Fields unused by the format are ignored.
- Accept rule: a field set is accepted on an edge where in_valid && in_ready.
- in_ready = !rst && !clr && !fifo_full && !prog_full && (accepted_cnt < 2^ADDR_W). Acceptance beyond memory capacity is therefore impossible.
- Full FIFO: in_ready is low even when a pop happens in the same cycle. There is no combinational pop-to-ready path.
- Latency: a word accepted at edge N is pushed into the FIFO at N. The earliest it appears on mem_wdata with mem_we=1 is after edge N, i.e. one cycle later.
- Output: mem_we = !fifo_empty && !prog_full. mem_wdata is the FIFO head; mem_addr is the write-address register.
- Write handshake: a write completes on an edge with mem_we && mem_ready. On completion the FIFO pops, mem_addr increments and count increments. mem_wdata and mem_addr are held stable while mem_we=1 and mem_ready=0.
- Ordering: words are written strictly in acceptance order, at consecutive addresses starting from 0.
- Capacity boundary: prog_full is set when the write to address 2^ADDR_W-1 completes. mem_addr wraps to 0 but no further writes occur until rst or clr.
- Simultaneous push and pop in the same cycle: FIFO occupancy is unchanged and both actions take effect.
- clr: same effect as rst on every register (FIFO flush, mem_addr=0, count=0, accepted_cnt=0, prog_full=0, err=0). Any in-flight write is dropped. rst has precedence over clr.
- Reset values: in_ready=0 while rst=1, mem_we=0, mem_addr=0, mem_wdata=0 (FIFO storage cleared), count=0, prog_full=0, err=0.
- Reset mid-operation: a handshake in the rst cycle is ignored. No write is reported complete in that cycle.

Optional Feature:
- Macro: ENC_FIELD_CHECK_EN.
- Defined: an accepted field set is illegal if any unused field is nonzero:
  - IMM4 format: rd, rs or imm2 nonzero.
  - RI format: rs or imm4 nonzero.
  - RR format: imm2 or imm4 nonzero.
- An illegal set is consumed (handshake completes) but not pushed and not counted. err is set and stays set until rst or clr.
- Undefined: unused fields are silently masked; err is tied to 0.

Decomposition:
- Shared package holds:
  - opcode constants OP_0..OP_F;
  - format enum FMT_IMM4, FMT_RI, FMT_RR;
  - function op_format(opcode), shared with the decoder for consistency;
  - INSTR_W = 8.
- Sub-module: instr_fifo, a synchronous FIFO with DEPTH words of 8 bits, push/pop/full/empty ports, synchronous reset and flush.

Test Plan:
- Encoding: opcode=3, rd=2, rs=1 -> mem_wdata=0x39 at mem_addr=0. opcode=0, imm4=0xA -> 0x0A at addr 1. opcode=9, rd=3, imm2=2 -> 0x9E at addr 2. count=3.
- Backpressure: hold mem_ready=0 with DEPTH=4 and drive 6 back-to-back sets -> in_ready falls after 4 accepts; mem_wdata stays stable. Release mem_ready -> all 6 words written in order to addresses 0-5.
- Capacity: ADDR_W=2 with 5 sets and mem_ready=1 -> writes to addresses 0-3, prog_full=1 after the 4th write, 5th set never accepted, mem_we=0.
- Clear: clr pulse mid-stream with 2 words queued -> FIFO empty, count=0, next accepted word written to address 0.
- Field check: opcode=3, rd=2, rs=1, imm4=5 -> with ENC_FIELD_CHECK_EN: err=1, no write, count unchanged. Without it: word 0x39 written, err=0.
- Reset mid-operation: assert rst during mem_we=1 && mem_ready=1 -> count stays 0, all outputs at reset values on the next cycle.
